lcd_write_arbiter: RTL and testbench
====================================

# lcd_write_arbiter

Shares the single `lcd_id` write channel between the LCD-side requesters: refresh engine, graph dispatcher and char-colour dispatcher. It arbitrates at burst boundaries and locks the grant for a whole burst. It enforces the post-dispatch guard interval, so a stale `write_ok` from the previous word is never taken as completion of the current one. It sits between the per-function sequencers inside the LCD controller and `lcd_id`, and replaces their hand-rolled `delay_time`/`write_ok` handshakes.

## Interface
- `NUM_REQ`, 3: number of requesters. Index 0 = refresh, 1 = graph, 2 = char.
- `GUARD_CYCLES`, 2: cycles after a dispatch during which `write_ok` is ignored. Legal range is 1..15.
- `pclk`  in  1: clock. Everything is on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `req_valid`  in  NUM_REQ: requester i has a word pending.
- `req_data`  in  NUM_REQ×32: word to send.
- `req_addr`  in  NUM_REQ×32: address/command tag for the word.
- `req_rs`  in  NUM_REQ: 0 = command, 1 = pixel data.
- `req_last`  in  NUM_REQ: the word ends the requester's burst.
- `req_ready`  out  NUM_REQ: word i is captured this cycle. Combinational.
- `write_ok`  in  1: `lcd_id` is idle and can take a word.
- `buffer_data`  out  32: word to `lcd_id`.
- `buffer_addr`  out  32: tag to `lcd_id`.
- `rs_o`  out  1: command/data select to `lcd_id`.
- `data_valid`  out  1: one-cycle dispatch strobe.
- `grant_o`  out  NUM_REQ: one-hot owner of the channel. 0 when no owner.
- `busy`  out  1: a burst is locked or a word is in flight.
- `word_cnt`  out  16: words dispatched in the current burst. Saturates at 16'hFFFF.

## Operation
- **Reset.** Every output is 0. The FSM enters IDLE, the lock is cleared and the RR pointer is 0.
- **IDLE.** No burst is locked.
  - If `write_ok` and any `req_valid` are high, pick a winner.
  - `req_ready[winner]` is 1 and the word is captured.
  - `grant_o` and the lock are set and `word_cnt` is cleared. The FSM goes to SEND.
- **SEND.** One cycle.
  - `data_valid` = 1 and `word_cnt` increments.
  - `buffer_*` and `rs_o` hold the captured word until the next capture.
  - The FSM goes to GUARD with the guard counter at 0.
- **GUARD.** Lasts `GUARD_CYCLES` cycles. `write_ok` is ignored and `data_valid` is 0. The FSM then goes to WAIT.
- **WAIT.** Stays until `write_ok` = 1. Then:
  - If the last captured word had `req_last` = 1, release the lock and clear `grant_o`.
    - If any request is valid, re-arbitrate this same cycle, exactly as in IDLE.
    - Otherwise go to IDLE.
  - If the burst is still locked and `req_valid[owner]` = 1, capture the owner's next word (`req_ready[owner]` = 1) and go to SEND.
  - If the burst is still locked and the owner's `req_valid` is 0, stay in WAIT and keep the lock. Other requesters are never served mid-burst.
- `req_ready` is asserted only in a capture cycle, and at most one bit is set.
- Simultaneous requests are resolved by the selection policy in Configuration.
- Reset during any state aborts the word. Outputs return to their reset values on the next edge, and requesters re-issue the word.

## Timing
- A capture at cycle t gives `data_valid` at t+1 and GUARD at t+2..t+1+G.
- The earliest next capture is t+2+G, when `write_ok` is already high. With G = 2 the minimum word period is 4 cycles.
- Re-arbitration from WAIT adds no cycle. The next burst's SEND is at t+3+G.
- `write_ok` is sampled only in IDLE and WAIT.
- `busy` = (state ≠ IDLE). `grant_o` is registered. `word_cnt` updates in SEND.

## Configuration
- `LCD_ARB_RR_EN` defined: round-robin.
  - The search starts at the index after the last burst owner.
  - The pointer updates on each new grant.
- `LCD_ARB_RR_EN` not defined: fixed priority, lowest index wins, so refresh beats graph beats char. No pointer register is built.

## Structure
- `lcd_pkg` holds:
  - the state enum `lcd_arb_state_t` (IDLE, SEND, GUARD, WAIT);
  - constants `LCD_REQ_REFRESH` = 0, `LCD_REQ_GRAPH` = 1, `LCD_REQ_CHAR` = 2;
  - the default `LCD_GUARD_CYCLES` = 2.
- The sub-module `lcd_arb_pick` is combinational. It maps the request vector and pointer to a one-hot winner and is shared by both policies.

## Test plan
- **Single burst.** Req 1 sends 3 words 32'h3600_0000, 32'h2a00_0028, 32'h2a02_01B7, with `req_last` on the third, and `write_ok` held high.
  - `data_valid` pulses at t+1, t+5 and t+9.
  - `word_cnt` ends at 3 and `grant_o` returns to 0.
- **Stale `write_ok`.** `write_ok` stays high through GUARD, then drops to 0 for 5 cycles.
  - No capture happens until `write_ok` rises again after GUARD.
- **Simultaneous requests (fixed priority).** Reqs 0 and 2 both become valid in IDLE.
  - Without the macro, req 0 wins. Req 2 is granted in the cycle req 0's last word completes.
- **Round-robin.** With `LCD_ARB_RR_EN`, all three requesters stay valid with single-word bursts.
  - Grant order is 0, 1, 2, 0.
- **Lock hold.** The owner drops `req_valid` mid-burst for 10 cycles while req 0 is valid.
  - Req 0 is never granted. The burst resumes when the owner's `req_valid` returns.
- **Reset mid-burst.** `rst_n` = 0 for 1 cycle during GUARD.
  - All outputs are 0 on the next edge, and a new request is served from IDLE.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD write-channel arbiter.
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } lcd_arb_state_t;

    localparam int LCD_REQ_REFRESH  = 0;
    localparam int LCD_REQ_GRAPH    = 1;
    localparam int LCD_REQ_CHAR     = 2;
    localparam int LCD_GUARD_CYCLES = 2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lcd_arb_pick.sv
// Combinational one-hot winner search starting at ptr_i and wrapping around.
// Fixed priority is the same search with ptr_i tied to 0.
module lcd_arb_pick
    import lcd_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic          found;
    logic [PW-1:0] sel;

    // Wrap-around scan: the first requester at or after the pointer wins.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel = PW'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[sel]) begin
                gnt_o[sel] = 1'b1;
                found      = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Burst-locked arbiter for the lcd_id write channel with a post-dispatch guard.
// Define LCD_ARB_RR_EN for round-robin selection; default is fixed priority.
module lcd_write_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int GUARD_CYCLES = LCD_GUARD_CYCLES
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_data,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ-1:0]    req_rs,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  write_ok,
    output logic [31:0]           buffer_data,
    output logic [31:0]           buffer_addr,
    output logic                  rs_o,
    output logic                  data_valid,
    output logic [NUM_REQ-1:0]    grant_o,
    output logic                  busy,
    output logic [15:0]           word_cnt
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    lcd_arb_state_t     state_q, state_d;
    logic [3:0]         guard_q, guard_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               last_q, last_d;
    logic [31:0]        data_q, data_d;
    logic [31:0]        addr_q, addr_d;
    logic               rs_q, rs_d;
    logic               dv_q, dv_d;
    logic               busy_q;
    logic [15:0]        cnt_q, cnt_d;

    logic [NUM_REQ-1:0] win_oh;
    logic [NUM_REQ-1:0] cap_sel;
    logic               new_burst;
    logic [31:0]        sel_data, sel_addr;
    logic [PW-1:0]      pick_ptr;

    lcd_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (pick_ptr),
        .gnt_o (win_oh)
    );

`ifdef LCD_ARB_RR_EN
    logic [PW-1:0] ptr_q, ptr_d, win_idx;

    // Next search starts just after the requester that won the newest burst.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_idx = win_oh[i] ? PW'(i) : win_idx;
        end
        if (new_burst) begin
            ptr_d = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign pick_ptr = ptr_q;
`else
    assign pick_ptr = '0;
`endif

    // Channel FSM: capture only from IDLE/WAIT, so write_ok is never seen during SEND/GUARD.
    always_comb begin
        state_d   = state_q;
        guard_d   = guard_q;
        grant_d   = grant_q;
        last_d    = last_q;
        data_d    = data_q;
        addr_d    = addr_q;
        rs_d      = rs_q;
        cnt_d     = cnt_q;
        dv_d      = 1'b0;
        cap_sel   = '0;
        new_burst = 1'b0;
        sel_data  = 32'd0;
        sel_addr  = 32'd0;
        case (state_q)
            IDLE: begin
                if (write_ok && (|req_valid)) begin
                    new_burst = 1'b1;
                    cap_sel   = win_oh;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                state_d = GUARD;
                guard_d = 4'd0;
                cnt_d   = sat_inc16(cnt_q);
            end
            GUARD: begin
                if (guard_q == 4'(GUARD_CYCLES - 1)) begin
                    state_d = WAIT;
                end else begin
                    guard_d = guard_q + 4'd1;
                end
            end
            WAIT: begin
                if (!write_ok) begin
                    state_d = WAIT;
                end else if (last_q) begin
                    if (|req_valid) begin
                        new_burst = 1'b1;
                        cap_sel   = win_oh;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (|(req_valid & grant_q)) begin
                    cap_sel = grant_q;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data = sel_data | (req_data[i*32 +: 32] & {32{cap_sel[i]}});
            sel_addr = sel_addr | (req_addr[i*32 +: 32] & {32{cap_sel[i]}});
        end

        if (|cap_sel) begin
            state_d = SEND;
            dv_d    = 1'b1;
            data_d  = sel_data;
            addr_d  = sel_addr;
            rs_d    = |(req_rs & cap_sel);
            last_d  = |(req_last & cap_sel);
            if (new_burst) begin
                grant_d = win_oh;
                cnt_d   = 16'd0;
            end else begin
                grant_d = grant_q;
            end
        end else begin
            dv_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            guard_q <= 4'd0;
            grant_q <= '0;
            last_q  <= 1'b0;
            data_q  <= 32'd0;
            addr_q  <= 32'd0;
            rs_q    <= 1'b0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            rs_q    <= rs_d;
            dv_q    <= dv_d;
            busy_q  <= (state_d != IDLE);
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready   = rst_n ? cap_sel : '0;
    assign buffer_data = data_q;
    assign buffer_addr = addr_q;
    assign rs_o        = rs_q;
    assign data_valid  = dv_q;
    assign grant_o     = grant_q;
    assign busy        = busy_q;
    assign word_cnt    = cnt_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed + randomized bench for lcd_write_arbiter against a cycle-count reference model.
module tb_lcd_write_arbiter;

    localparam int N = 3;
    localparam int G = 2;

    logic            pclk, rst_n, write_ok;
    logic [N-1:0]    req_valid, req_rs, req_last, req_ready, grant_o;
    logic [N*32-1:0] req_data, req_addr;
    logic [31:0]     buffer_data, buffer_addr;
    logic            rs_o, data_valid, busy;
    logic [15:0]     word_cnt;
    logic [31:0]     rd [N];
    logic [31:0]     ra [N];

    assign req_data = {rd[2], rd[1], rd[0]};
    assign req_addr = {ra[2], ra[1], ra[0]};

    lcd_write_arbiter #(.NUM_REQ(N), .GUARD_CYCLES(G)) dut (
        .pclk(pclk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_addr(req_addr), .req_rs(req_rs), .req_last(req_last), .req_ready(req_ready),
        .write_ok(write_ok), .buffer_data(buffer_data), .buffer_addr(buffer_addr),
        .rs_o(rs_o), .data_valid(data_valid), .grant_o(grant_o), .busy(busy),
        .word_cnt(word_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: m_since counts edges since the last capture (1 = dispatch cycle).
    int           m_since, m_owner, m_ptr;
    logic         m_last, m_rs;
    logic [15:0]  m_cnt;
    logic [31:0]  m_data, m_addr;
    logic [N-1:0] m_cap, last_cap;
    logic         m_newb, m_rel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_since = G + 2; m_owner = -1; m_ptr = 0; m_last = 1'b0; m_rs = 1'b0;
        m_cnt = 16'd0; m_data = 32'd0; m_addr = 32'd0;
    endtask

    function automatic logic [N-1:0] pick_model(input logic [N-1:0] v, input int start);
        logic [N-1:0] r;
        int idx;
        r = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (start + k) % N;
            if (v[idx]) r = '0;
            if (v[idx]) r[idx] = 1'b1;
        end
        return r;
    endfunction

    task automatic step();
        int idx;
        int start;
        logic [N-1:0] g;
        #1;
`ifdef LCD_ARB_RR_EN
        start = m_ptr;
`else
        start = 0;
`endif
        m_cap = '0; m_newb = 1'b0; m_rel = 1'b0;
        if (rst_n && m_since >= G + 2 && write_ok) begin
            if (m_owner < 0 || m_last) begin
                m_cap  = pick_model(req_valid, start);
                m_newb = |m_cap;
                m_rel  = !m_newb && (m_owner >= 0);
            end else if (req_valid[m_owner]) begin
                m_cap[m_owner] = 1'b1;
            end
        end
        chk("req_ready", 32'(req_ready), 32'(m_cap));
        @(posedge pclk);
        #1;
        cyc++;
        if (!rst_n) begin
            reset_model();
        end else begin
            if (m_since == 1) m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
            if (m_since < G + 2) m_since++;
            if (m_rel) m_owner = -1;
            if (|m_cap) begin
                idx = 0;
                for (int i = 0; i < N; i++) if (m_cap[i]) idx = i;
                m_data  = req_data[idx*32 +: 32];
                m_addr  = req_addr[idx*32 +: 32];
                m_rs    = req_rs[idx];
                m_last  = req_last[idx];
                m_since = 1;
                if (m_newb) begin
                    m_owner = idx; m_cnt = 16'd0; m_ptr = (idx + 1) % N;
                end
            end
        end
        last_cap = rst_n ? m_cap : '0;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        chk("data_valid", 32'(data_valid), 32'(m_since == 1));
        chk("grant_o", 32'(grant_o), 32'(g));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
        chk("buffer_data", buffer_data, m_data);
        chk("buffer_addr", buffer_addr, m_addr);
        chk("rs_o", 32'(rs_o), 32'(m_rs));
    endtask

    task automatic send_word(input int i, input logic [31:0] d, input logic [31:0] a,
                             input logic rs, input logic l);
        logic got;
        rd[i] = d; ra[i] = a; req_rs[i] = rs; req_last[i] = l; req_valid[i] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            step();
            got = last_cap[i];
        end
        chk("capture_seen", 32'(got), 32'd1);
        req_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] order [4];
        logic [N-1:0] exp_rr [4];
        logic         seen;
        int           cnt, t1, t2;
        reset_model();
        rst_n = 1'b0; write_ok = 1'b0; req_valid = '0; req_rs = '0; req_last = '0;
        for (int i = 0; i < N; i++) begin rd[i] = 32'd0; ra[i] = 32'd0; end
        step(); step();
        rst_n = 1'b1;
        step();
        chk("reset_busy", 32'(busy), 32'd0);

        // single burst from the graph requester
        write_ok = 1'b1;
        send_word(1, 32'h3600_0000, 32'h0000_0036, 1'b0, 1'b0);
        send_word(1, 32'h2a00_0028, 32'h0000_002a, 1'b1, 1'b0);
        send_word(1, 32'h2a02_01B7, 32'h0000_002b, 1'b1, 1'b1);
        repeat (6) step();
        chk("burst_word_cnt", 32'(word_cnt), 32'd3);
        chk("burst_grant_end", 32'(grant_o), 32'd0);

        // stale write_ok through the guard window
        do_reset();
        write_ok = 1'b1;
        send_word(0, 32'h1111_0000, 32'h0000_0001, 1'b0, 1'b0);
        rd[0] = 32'h1111_0001; req_last[0] = 1'b1; req_valid[0] = 1'b1;
        seen = 1'b0;
        repeat (G + 1) begin step(); seen = seen | last_cap[0]; end
        write_ok = 1'b0;
        repeat (5) begin step(); seen = seen | last_cap[0]; end
        chk("stale_no_capture", 32'(seen), 32'd0);
        write_ok = 1'b1;
        step();
        chk("stale_capture", 32'(last_cap[0]), 32'd1);
        req_valid = '0;
        repeat (G + 3) step();

        // simultaneous requests 0 and 2
        do_reset();
        req_last = 3'b101; rd[0] = 32'hA0A0_0000; rd[2] = 32'hC2C2_0000;
        req_valid = 3'b101; cnt = 0; t1 = 0; t2 = 0;
        for (int k = 0; k < 40 && cnt < 2; k++) begin
            step();
            if (|last_cap) begin
                order[cnt] = last_cap;
                if (cnt == 0) t1 = cyc; else t2 = cyc;
                cnt++;
                req_valid = req_valid & ~last_cap;
            end
        end
        chk("simul_first", 32'(order[0]), 32'h1);
        chk("simul_second", 32'(order[1]), 32'h4);
        chk("simul_gap", 32'(t2 - t1), 32'(G + 2));
        repeat (G + 3) step();

        // all three valid, single-word bursts
        do_reset();
`ifdef LCD_ARB_RR_EN
        exp_rr[0] = 3'b001; exp_rr[1] = 3'b010; exp_rr[2] = 3'b100; exp_rr[3] = 3'b001;
`else
        exp_rr[0] = 3'b001; exp_rr[1] = 3'b001; exp_rr[2] = 3'b001; exp_rr[3] = 3'b001;
`endif
        req_last = 3'b111; req_valid = 3'b111; cnt = 0;
        for (int k = 0; k < 60 && cnt < 4; k++) begin
            step();
            if (|last_cap) begin order[cnt] = last_cap; cnt++; end
        end
        for (int j = 0; j < 4; j++) chk("rr_order", 32'(order[j]), 32'(exp_rr[j]));
        req_valid = '0;
        repeat (G + 3) step();

        // lock hold while the owner pauses mid-burst
        do_reset();
        req_last = '0;
        send_word(1, 32'h5555_0001, 32'h0000_0010, 1'b1, 1'b0);
        req_valid[0] = 1'b1; seen = 1'b0;
        repeat (10) begin step(); seen = seen | last_cap[0]; end
        chk("lock_no_req0", 32'(seen), 32'd0);
        chk("lock_grant_held", 32'(grant_o), 32'h2);
        send_word(1, 32'h5555_0002, 32'h0000_0011, 1'b1, 1'b1);
        repeat (G + 4) step();
        req_valid = '0;
        repeat (G + 4) step();

        // reset during GUARD
        do_reset();
        send_word(2, 32'h7777_0001, 32'h0000_0020, 1'b1, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_buffer_data", buffer_data, 32'd0);
        chk("midrst_grant", 32'(grant_o), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        send_word(0, 32'h8888_0001, 32'h0000_0030, 1'b0, 1'b1);
        chk("postrst_grant", 32'(grant_o), 32'h1);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            req_valid = N'($urandom_range(7));
            req_last  = N'($urandom_range(7));
            req_rs    = N'($urandom_range(7));
            for (int i = 0; i < N; i++) begin rd[i] = $urandom; ra[i] = $urandom; end
            write_ok  = ($urandom_range(3) != 0);
            rst_n     = ($urandom_range(199) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
